// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU-function decode with HI/LO mul/div sequencing
// and hazard stall generation for the MIPS execute stage.
module alu_ctrl_seq #(
  parameter int OPW     = 6,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_valid,
  input  logic [OPW-1:0] i_aluOp,
  input  logic [OPW-1:0] i_func,
  input  logic           i_r_field,
  output logic [OPW-1:0] o_aluControl,
  output logic           o_ALUSrc_op1,
  output logic           o_illegal,
  output logic           o_md_start,
  output logic [1:0]     o_md_op,
  output logic           o_hi_we,
  output logic           o_lo_we,
  output logic [1:0]     o_hilo_rd,
  output logic           o_busy,
  output logic           o_stall
);

  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  // opcodes
  localparam logic [OPW-1:0] OP_R     = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b001001);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_XORI  = OPW'(6'b001110);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(6'b001111);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  // R-type functions / ALU codes
  localparam logic [OPW-1:0] F_SLL    = OPW'(6'b000000);
  localparam logic [OPW-1:0] F_SRL    = OPW'(6'b000010);
  localparam logic [OPW-1:0] F_SRA    = OPW'(6'b000011);
  localparam logic [OPW-1:0] F_SLLV   = OPW'(6'b000100);
  localparam logic [OPW-1:0] F_SRLV   = OPW'(6'b000110);
  localparam logic [OPW-1:0] F_SRAV   = OPW'(6'b000111);
  localparam logic [OPW-1:0] F_MFHI   = OPW'(6'b010000);
  localparam logic [OPW-1:0] F_MTHI   = OPW'(6'b010001);
  localparam logic [OPW-1:0] F_MFLO   = OPW'(6'b010010);
  localparam logic [OPW-1:0] F_MTLO   = OPW'(6'b010011);
  localparam logic [OPW-1:0] F_MULT   = OPW'(6'b011000);
  localparam logic [OPW-1:0] F_MULTU  = OPW'(6'b011001);
  localparam logic [OPW-1:0] F_DIV    = OPW'(6'b011010);
  localparam logic [OPW-1:0] F_DIVU   = OPW'(6'b011011);
  localparam logic [OPW-1:0] F_ADD    = OPW'(6'b100000);
  localparam logic [OPW-1:0] F_ADDU   = OPW'(6'b100001);
  localparam logic [OPW-1:0] F_SUB    = OPW'(6'b100010);
  localparam logic [OPW-1:0] F_SUBU   = OPW'(6'b100011);
  localparam logic [OPW-1:0] F_AND    = OPW'(6'b100100);
  localparam logic [OPW-1:0] F_OR     = OPW'(6'b100101);
  localparam logic [OPW-1:0] F_XOR    = OPW'(6'b100110);
  localparam logic [OPW-1:0] F_NOR    = OPW'(6'b100111);
  localparam logic [OPW-1:0] F_SLT    = OPW'(6'b101010);
  localparam logic [OPW-1:0] F_SLTU   = OPW'(6'b101011);
  localparam logic [OPW-1:0] A_LUI    = OPW'(6'b111100);
  localparam logic [OPW-1:0] A_ROTR   = OPW'(6'b111110);
  localparam logic [OPW-1:0] A_ROTRV  = OPW'(6'b111111);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t         state, nxt;
  logic [CW-1:0]  cnt, cnt_nxt;

  logic [OPW-1:0] dec_alu;
  logic           dec_src1, dec_ill, hilo_cls, is_mul, is_div, is_mthi, is_mtlo;
  logic [1:0]     dec_rd;
  logic           accept;

  // combinational decode of the instruction sitting in decode
  always_comb begin
    dec_alu  = '0;
    dec_src1 = 1'b0;
    dec_ill  = 1'b0;
    dec_rd   = 2'b00;
    hilo_cls = 1'b0;
    is_mul   = 1'b0;
    is_div   = 1'b0;
    is_mthi  = 1'b0;
    is_mtlo  = 1'b0;
    case (i_aluOp)
      OP_R: begin
        case (i_func)
          F_ADD, F_ADDU, F_AND, F_OR, F_SUB, F_SUBU, F_SLT, F_SLTU,
          F_NOR, F_XOR, F_SLLV, F_SRAV: dec_alu = i_func;
          F_SRLV:       dec_alu = i_r_field ? A_ROTRV : F_SRLV;
          F_SLL, F_SRA: begin dec_alu = i_func; dec_src1 = 1'b1; end
          F_SRL:        begin dec_alu = i_r_field ? A_ROTR : F_SRL; dec_src1 = 1'b1; end
          F_MFHI:       begin hilo_cls = 1'b1; dec_rd = 2'b10; end
          F_MFLO:       begin hilo_cls = 1'b1; dec_rd = 2'b01; end
          F_MTHI:       begin hilo_cls = 1'b1; is_mthi = 1'b1; end
          F_MTLO:       begin hilo_cls = 1'b1; is_mtlo = 1'b1; end
          F_MULT, F_MULTU: begin hilo_cls = 1'b1; is_mul = 1'b1; end
          F_DIV, F_DIVU:   begin hilo_cls = 1'b1; is_div = 1'b1; end
          default:      dec_ill = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: dec_alu = F_ADD;
      OP_BEQ, OP_BNE:                  dec_alu = F_SUB;
      OP_LUI:                          dec_alu = A_LUI;
      OP_ORI:                          dec_alu = F_OR;
      OP_XORI:                         dec_alu = F_XOR;
      OP_ANDI:                         dec_alu = F_AND;
      default:                         dec_alu = '0;
    endcase
  end

  assign o_busy  = (state != IDLE);
  assign o_stall = i_valid & o_busy & hilo_cls;
  assign accept  = i_valid & ~o_stall;

  // mul/div sequencer next state; the start cycle does not count toward LAT
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: begin
        if (accept && is_mul) begin
          nxt     = MUL;
          cnt_nxt = CW'(MUL_LAT - 1);
        end else if (accept && is_div) begin
          nxt     = DIV;
          cnt_nxt = CW'(DIV_LAT - 1);
        end
      end
      MUL, DIV: begin
        if (!o_md_start) begin
          if (cnt == '0) nxt = DONE;
          else           cnt_nxt = cnt - CW'(1);
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // sequencer state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // registered control outputs; pulses self-clear, levels hold when not accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_aluControl <= '0;
      o_ALUSrc_op1 <= 1'b0;
      o_illegal    <= 1'b0;
      o_md_start   <= 1'b0;
      o_md_op      <= 2'b00;
      o_hi_we      <= 1'b0;
      o_lo_we      <= 1'b0;
      o_hilo_rd    <= 2'b00;
    end else begin
      o_illegal  <= accept & dec_ill;
      o_md_start <= accept & (is_mul | is_div);
      o_hi_we    <= (nxt == DONE) | (accept & is_mthi);
      o_lo_we    <= (nxt == DONE) | (accept & is_mtlo);
      if (accept) begin
        o_aluControl <= dec_alu;
        o_ALUSrc_op1 <= dec_src1;
        o_hilo_rd    <= dec_rd;
        if (is_mul | is_div) o_md_op <= {is_div, i_func[0]};
      end
    end
  end

endmodule
